// File: rtl/emds_serial_pkg.sv
// Shared definitions for the messenger serial link: frame constants and receive FSM states.
// The framed transmitter is expected to import this package as well.
package emds_serial_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned PARITY_EN_DEF  = 1;
  localparam logic        IDLE_LEVEL_DEF = 1'b1;

  localparam logic        START_BIT = ~IDLE_LEVEL_DEF;
  localparam logic        STOP_BIT  = IDLE_LEVEL_DEF;
  localparam int unsigned FRAME_LEN = 1 + DATA_WIDTH_DEF + PARITY_EN_DEF + 1;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_DATA   = 3'd1,
    RX_PARITY = 3'd2,
    RX_STOP   = 3'd3,
    RX_BREAK  = 3'd4
  } rx_state_t;

  // Line-level helpers for instances that override the idle level.
  function automatic logic start_bit(input logic idle_level);
    return ~idle_level;
  endfunction

  function automatic logic stop_bit(input logic idle_level);
    return idle_level;
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned parity_en);
    return 1 + data_width + parity_en + 1;
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Data-bit counter for the frame receiver: cleared on the start bit, counts data samples.
module rx_bit_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  // High while the final data sample of the frame is on the line.
  assign last_c = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/serial_frame_receiver.sv
// Framed serial receiver: start, LSB-first data, optional even parity, stop.
// Checked bytes are offered through a one-entry valid/ready holding register.
module serial_frame_receiver
  import emds_serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          PARITY_EN  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  overrun
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam logic        START_L = start_bit(IDLE_LEVEL);
  localparam logic        STOP_L  = stop_bit(IDLE_LEVEL);

  rx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_bit;
  logic                  last_c;
  logic                  start_c;
  logic                  parity_bad_c;

  assign start_c      = (state == RX_IDLE) && (serial_in == START_L);
  assign parity_bad_c = ^{shift_reg, parity_bit};

  rx_bit_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (DATA_WIDTH - 1)
  ) u_bit_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_c),
    .enable (state == RX_DATA),
    .last_c (last_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RX_IDLE;
      shift_reg     <= '0;
      parity_bit    <= 1'b0;
      byte_out      <= '0;
      byte_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end

      case (state)
        RX_IDLE: begin
          if (serial_in == START_L) begin
            state <= RX_DATA;
          end
        end
        RX_DATA: begin
          shift_reg <= {serial_in, shift_reg[DATA_WIDTH-1:1]};
          if (last_c) begin
            state <= PARITY_EN ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: begin
          parity_bit <= serial_in;
          state      <= RX_STOP;
        end
        RX_STOP: begin
          // A bad stop bit outranks a parity failure and forces a wait for idle.
          if (serial_in != STOP_L) begin
            framing_error <= 1'b1;
            state         <= RX_BREAK;
          end else if (PARITY_EN && parity_bad_c) begin
            parity_error <= 1'b1;
            state        <= RX_IDLE;
          end else begin
            state <= RX_IDLE;
            if (!byte_valid || byte_ready) begin
              byte_out   <= shift_reg;
              byte_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        RX_BREAK: begin
          if (serial_in == IDLE_LEVEL) begin
            state <= RX_IDLE;
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver with hand-computed frames and expectations.
module tb_serial_frame_receiver;

  logic       clock;
  logic       reset;
  logic       serial_in;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;

  int total;
  int bad;
  int pe_cnt;
  int fe_cnt;
  int ov_cnt;

  serial_frame_receiver #(
    .DATA_WIDTH (8),
    .PARITY_EN  (1'b1),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .serial_in     (serial_in),
    .byte_out      (byte_out),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pulses are one cycle wide, so one negedge sample counts each exactly once.
  always @(negedge clock) begin
    if (parity_error)  pe_cnt <= pe_cnt + 1;
    if (framing_error) fe_cnt <= fe_cnt + 1;
    if (overrun)       ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clock);
    serial_in = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // Advance past the next sampling edge and settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // par_flip inverts the correct even parity bit; stop is the stop-bit level.
  task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit((^data) ^ par_flip);
    drive_bit(stop);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; pe_cnt = 0; fe_cnt = 0; ov_cnt = 0;
    reset = 1'b1; serial_in = 1'b1; byte_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_byte_out", 32'(byte_out), 32'h0);
    check("rst_valid", 32'(byte_valid), 32'h0);
    check("rst_errs", 32'({parity_error, framing_error, overrun}), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);

    // 0xA5, good parity, consumer ready
    send_frame(8'hA5, 1'b0, 1'b1);
    step();
    check("a5_byte", 32'(byte_out), 32'hA5);
    check("a5_valid", 32'(byte_valid), 32'h1);
    idle(1);
    step();
    check("a5_valid_clear", 32'(byte_valid), 32'h0);
    check("a5_no_errs", 32'(pe_cnt + fe_cnt + ov_cnt), 32'h0);

    // 0x01 with wrong parity, then a good 0x2B back-to-back
    send_frame(8'h01, 1'b1, 1'b1);
    step();
    check("par_valid", 32'(byte_valid), 32'h0);
    send_frame(8'h2B, 1'b0, 1'b1);
    step();
    check("par_pe_cnt", 32'(pe_cnt), 32'h1);
    check("2b_byte", 32'(byte_out), 32'h2B);
    check("2b_valid", 32'(byte_valid), 32'h1);

    // 0x3C with bad stop bit, line held low, then recovery with 0x55
    send_frame(8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b0);
    idle(2);
    check("brk_fe_cnt", 32'(fe_cnt), 32'h1);
    check("brk_pe_cnt", 32'(pe_cnt), 32'h1);
    check("brk_byte_kept", 32'(byte_out), 32'h2B);
    send_frame(8'h55, 1'b0, 1'b1);
    step();
    check("55_byte", 32'(byte_out), 32'h55);
    check("55_valid", 32'(byte_valid), 32'h1);
    check("55_errs", 32'(fe_cnt + pe_cnt), 32'h2);

    // Overrun: consumer stalled across back-to-back 0x3C, 0xC3
    idle(2);
    byte_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b1);
    step();
    check("ov_first_byte", 32'(byte_out), 32'h3C);
    check("ov_first_valid", 32'(byte_valid), 32'h1);
    send_frame(8'hC3, 1'b0, 1'b1);
    step();
    check("ov_byte_kept", 32'(byte_out), 32'h3C);
    check("ov_valid", 32'(byte_valid), 32'h1);
    @(negedge clock);
    byte_ready = 1'b1;
    serial_in  = 1'b1;
    step();
    check("ov_cnt", 32'(ov_cnt), 32'h1);
    check("ov_drain_valid", 32'(byte_valid), 32'h0);
    check("ov_drain_byte", 32'(byte_out), 32'h3C);

    // Accept and load on the same edge
    byte_ready = 1'b0;
    idle(1);
    send_frame(8'h11, 1'b0, 1'b1);
    step();
    check("11_byte", 32'(byte_out), 32'h11);
    send_frame(8'h22, 1'b0, 1'b1);
    byte_ready = 1'b1;
    step();
    check("22_byte", 32'(byte_out), 32'h22);
    check("22_valid", 32'(byte_valid), 32'h1);
    idle(1);
    check("22_no_ov", 32'(ov_cnt), 32'h1);

    // Reset mid-frame after 4 data bits of 0xFF
    idle(2);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    @(negedge clock);
    reset = 1'b1;
    serial_in = 1'b1;
    step();
    check("mid_rst_byte", 32'(byte_out), 32'h0);
    check("mid_rst_valid", 32'(byte_valid), 32'h0);
    check("mid_rst_errs", 32'({parity_error, framing_error, overrun}), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    idle(2);
    send_frame(8'h7E, 1'b0, 1'b1);
    step();
    check("7e_byte", 32'(byte_out), 32'h7E);
    check("7e_valid", 32'(byte_valid), 32'h1);
    idle(2);
    check("7e_errs", 32'(pe_cnt + fe_cnt + ov_cnt), 32'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
